// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;
  localparam int MDU_DW = 32;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
module mdu_div_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem
);
  logic [DW-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [DW:0]   shifted;
  logic [DW-1:0] diff;
  logic          ge;

  always_comb begin
    shifted = {rem_q, quo_q[DW-1]};
    ge      = shifted >= {1'b0, dvs_q};
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    diff    = shifted[DW-1:0] - dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = ge ? diff : shifted[DW-1:0];
      quo_d = {quo_q[DW-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply (IDLE -> FIX).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  input  logic                  hiWrite,
  input  logic                  loWrite,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  logic [1:0]      state_q, state_d, op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, divz_q, divz_d, done_q, done_d;

  logic            is_signed, a_neg, b_neg, mt_wr, accept;
  logic [DW-1:0]   a_mag, b_mag, quo, rem;
  logic [DW:0]     sum;
  logic [2*DW-1:0] prod_next, prod_full, prod_fix;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & opA[DW-1];
    b_neg     = is_signed & opB[DW-1];
    a_mag     = a_neg ? -opA : opA;
    b_mag     = b_neg ? -opB : opB;
    mt_wr     = (state_q == ST_IDLE) & (hiWrite | loWrite);
    accept    = (state_q == ST_IDLE) & start & ~hiWrite & ~loWrite;
    // Shift-add: multiplier sits in the low half and shifts out as the product shifts in.
    sum       = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    prod_next = {sum, prod_q[DW-1:1]};
`ifdef MDU_FAST_MUL_EN
    prod_full = {{DW{1'b0}}, a_mag_q} * {{DW{1'b0}}, b_mag_q};
`else
    prod_full = prod_q;
`endif
    prod_fix  = neg_q ? -prod_full : prod_full;
  end

  mdu_div_core #(.DW(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     ((state_q == ST_CALC) & op_q[1]),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo),
    .rem      (rem)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mt_wr) begin
          if (hiWrite) hi_d = din;
          if (loWrite) lo_d = din;
        end else if (accept) begin
          op_d    = op;
          cnt_d   = '0;
          a_mag_d = a_mag;
          b_mag_d = b_mag;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          divz_d  = (opB == '0);
          prod_d  = {{DW{1'b0}}, b_mag};
`ifdef MDU_FAST_MUL_EN
          state_d = op[1] ? ST_CALC : ST_FIX;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) prod_d = prod_next;
        if (cnt_q == CW'(DW - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*DW-1:DW];
          lo_d = prod_fix[DW-1:0];
        end else if (divz_q) begin
          // Divide by zero returns all-ones quotient and the original dividend.
          lo_d = '1;
          hi_d = rneg_q ? -a_mag_q : a_mag_q;
        end else begin
          lo_d = neg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency, MT writes, reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] opA, opB, din;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .hiWrite(hiWrite), .loWrite(loWrite), .din(din),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op, count busy cycles, verify HI/LO hold until the result, then the result and done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo, input bit disturb);
    logic [31:0] hi0, lo0;
    int          n;
    bit          held;
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    hi0 = hi; lo0 = lo;
    @(negedge clk);
    start = 1'b0; opA = 32'hDEAD_BEEF; opB = 32'h0;
    n = 0; held = 1'b1;
    while (busy && n < 100) begin
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      if (disturb && n == 5) begin
        start = 1'b1; loWrite = 1'b1; hiWrite = 1'b1; din = 32'hBAD0_BAD0; op = MDU_MULT;
      end else begin
        start = 1'b0; loWrite = 1'b0; hiWrite = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; loWrite = 1'b0; hiWrite = 1'b0;
    check({tag, " busy_cycles"}, n, lat);
    check({tag, " hilo_held"}, {31'b0, held}, 32'd1);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    @(negedge clk);
    check({tag, " done_clear"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    op = MDU_MULT; opA = '0; opB = '0; din = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    rst = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
    run_op("divu_zero", MDU_DIVU, 32'h1234_5678, 32'h0, DIV_LAT, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1'b0);

    // MTHI together with start: write wins, start dropped.
    @(negedge clk);
    hiWrite = 1'b1; din = 32'h1111_1111; start = 1'b1; op = MDU_DIVU; opA = 32'd9; opB = 32'd3;
    @(negedge clk);
    hiWrite = 1'b0; start = 1'b0;
    check("mthi hi", hi, 32'h1111_1111);
    check("mthi lo_kept", lo, 32'h8000_0000);
    check("mthi busy", {31'b0, busy}, 32'd0);
    check("mthi done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("mthi busy_later", {31'b0, busy}, 32'd0);

    run_op("divu_disturb", MDU_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b1);

    // Reset dropped in the middle of a DIV.
    @(negedge clk);
    op = MDU_DIV; opA = 32'hFFFF_FFF9; opB = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("rst done_later", {31'b0, done}, 32'd0);
    rst = 1'b1;

    run_op("mult_post_rst", MDU_MULT, 32'd3, 32'd4, MUL_LAT, 32'h0, 32'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
